fp_cmp_pipe: RTL
================

Name: fp_cmp_pipe

Overview:
Parametrised, pipelined IEEE-754 comparator and min/max unit. It supports any binary format via EXP_W/MANT_W, with fp64 as the default. It adds a valid/ready handshake, op modes (quiet compare, signaling compare, min, max), sNaN/invalid detection and a sticky invalid flag. It sits in the FP datapath beside the add/mul units and feeds compare/branch and min/max instructions.

Parameters:
EXP_W, 11, exponent field width (>=2)
MANT_W, 52, stored mantissa field width (>=2)
W, 1+EXP_W+MANT_W, operand width (derived; not overridden)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands/op valid
in_ready  output  1  unit accepts operands this cycle
a  input  W  operand a
b  input  W  operand b
op  input  2  00 CMP_QUIET, 01 MIN, 10 MAX, 11 CMP_SIGNALING
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
lt  output  1  a<b
eq  output  1  a==b
gt  output  1  a>b
unord  output  1  a or b is NaN
res  output  W  MIN/MAX result; all zero for CMP ops
invalid  output  1  invalid-operation exception for this result
sticky_invalid  output  1  OR of all delivered invalid results since last clear
flag_clr  input  1  clears sticky_invalid

Behaviour:
- Reset (rst_n low, async): both stage valids = 0, out_valid = 0, lt/eq/gt/unord/invalid = 0, res = 0, sticky_invalid = 0. Any in-flight data is discarded. in_ready = 1 from the first cycle after release.
- Pipeline, two register stages:
  - S1 captures a, b, op and classification: NaN, sNaN, zero, sign, magnitude a>b, magnitude a==b.
  - S2 registers the flags and res.
  - Latency is exactly 2 cycles from accept (in_valid&&in_ready) to out_valid. Throughput is 1/cycle.
- Flow control:
  - adv2 = !s2_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1. This is combinational from out_ready; there is no in_valid -> in_ready path.
  - Bubbles collapse: S1 fills while S2 is stalled, provided S1 is empty.
  - While out_valid && !out_ready, all outputs stay stable.
- Classification:
  - NaN: exp all ones and mant != 0.
  - sNaN: NaN with mant MSB = 0.
  - Zero: exp = 0 and mant = 0.
  - Subnormals compare by raw magnitude bits; no flush.
- Compare flags, computed for every op:
  - Any NaN -> unord = 1, lt/eq/gt = 0.
  - Both zero, any signs -> eq.
  - Signs differ -> the negative operand is smaller.
  - Same sign -> magnitude compare, inverted when negative.
  - Exactly one of lt/eq/gt/unord is set per result.
- invalid:
  - Set if either operand is sNaN, for any op.
  - In CMP_SIGNALING, also set if either operand is a qNaN.
- res, MIN/MAX:
  - Either operand sNaN -> canonical qNaN (sign 0, exp all ones, mant MSB 1, rest 0).
  - Both qNaN -> canonical qNaN.
  - Exactly one qNaN -> the other operand, bit-exact.
  - Both zero -> MIN returns -0 if either is -0, MAX returns +0 if either is +0.
  - Equal nonzero -> a.
  - Otherwise the smaller (MIN) or larger (MAX) operand.
- sticky_invalid:
  - Sets on a handshake (out_valid && out_ready && invalid).
  - flag_clr clears it next cycle.
  - Simultaneous set and clear -> set wins (stays 1).
- flag_clr has no effect on the data pipeline.

Test Plan:
- CMP_QUIET a=0x3FF0000000000000 (1.0), b=0x4000000000000000 (2.0), out_ready=1 -> 2 cycles later out_valid=1, lt=1, res=0, invalid=0; swapped operands -> gt=1.
- CMP_QUIET a=0x0000000000000000, b=0x8000000000000000 -> eq=1. MIN of the same pair -> res=0x8000000000000000; MAX -> res=0x0000000000000000.
- a=0x7FF8000000000000 (qNaN), b=1.0:
  - CMP_QUIET -> unord=1, invalid=0.
  - CMP_SIGNALING -> unord=1, invalid=1, sticky_invalid=1 the cycle after the handshake.
  - MIN -> res=0x3FF0000000000000.
- MAX a=0x7FF0000000000001 (sNaN), b=0x7FF0000000000000 (+inf) -> res=0x7FF8000000000000, invalid=1. Assert flag_clr together with a second invalid handshake -> sticky_invalid stays 1. flag_clr alone -> 0.
- Back-to-back 8 ops with out_ready toggling randomly -> in-order results, no drop/duplicate, outputs stable during stall, in_ready=0 only when both stages are full and out_ready=0.
- Assert rst_n low with two ops in flight -> out_valid=0 immediately. After release, a new op completes in 2 cycles with correct flags. Repeat with EXP_W=8, MANT_W=23: 0x3F800000 vs 0xBF800000 -> gt=1.

Source files
------------

// File: rtl/fp_cmp_pipe.sv
// Two-stage pipelined IEEE-754 comparator and min/max unit.
// Stage 1 registers operands plus their classification, stage 2 registers
// the compare flags, the min/max result and the invalid exception.
module fp_cmp_pipe #(
  parameter  int EXP_W  = 11,
  parameter  int MANT_W = 52,
  localparam int W      = 1 + EXP_W + MANT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         lt,
  output logic         eq,
  output logic         gt,
  output logic         unord,
  output logic [W-1:0] res,
  output logic         invalid,
  output logic         sticky_invalid,
  input  logic         flag_clr
);

  localparam logic [1:0] OP_MIN   = 2'b01;
  localparam logic [1:0] OP_MAX   = 2'b10;
  localparam logic [1:0] OP_CMP_S = 2'b11;

  localparam logic [W-1:0] CANON_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

  // operand classification, evaluated on the raw inputs
  logic a_nan, b_nan, a_snan, b_snan, a_zero, b_zero, mag_gt, mag_eq;

  assign a_nan  = (&a[W-2:MANT_W]) && (|a[MANT_W-1:0]);
  assign b_nan  = (&b[W-2:MANT_W]) && (|b[MANT_W-1:0]);
  assign a_snan = a_nan && !a[MANT_W-1];
  assign b_snan = b_nan && !b[MANT_W-1];
  assign a_zero = ~|a[W-2:0];
  assign b_zero = ~|b[W-2:0];
  // subnormals need no special case: the biased exponent/mantissa bits
  // order monotonically with magnitude
  assign mag_gt = a[W-2:0] > b[W-2:0];
  assign mag_eq = a[W-2:0] == b[W-2:0];

  logic         s1_valid, s2_valid;
  logic [W-1:0] s1_a, s1_b;
  logic [1:0]   s1_op;
  logic         s1_a_nan, s1_b_nan, s1_a_snan, s1_b_snan;
  logic         s1_a_zero, s1_b_zero, s1_mag_gt, s1_mag_eq;
  logic         adv1, adv2;

  // a stage may load when it is empty or its contents move on this cycle
  assign adv2     = !s2_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  // stage 1: operand and classification capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_op     <= 2'b00;
      s1_a_nan  <= 1'b0;
      s1_b_nan  <= 1'b0;
      s1_a_snan <= 1'b0;
      s1_b_snan <= 1'b0;
      s1_a_zero <= 1'b0;
      s1_b_zero <= 1'b0;
      s1_mag_gt <= 1'b0;
      s1_mag_eq <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a      <= a;
        s1_b      <= b;
        s1_op     <= op;
        s1_a_nan  <= a_nan;
        s1_b_nan  <= b_nan;
        s1_a_snan <= a_snan;
        s1_b_snan <= b_snan;
        s1_a_zero <= a_zero;
        s1_b_zero <= b_zero;
        s1_mag_gt <= mag_gt;
        s1_mag_eq <= mag_eq;
      end
    end
  end

  logic         c_lt, c_eq, c_gt, c_unord, c_invalid;
  logic [W-1:0] c_res;
  logic         a_sign, b_sign;

  assign a_sign = s1_a[W-1];
  assign b_sign = s1_b[W-1];

  // compare flags, invalid detection and min/max selection from stage 1
  always_comb begin
    c_lt      = 1'b0;
    c_eq      = 1'b0;
    c_gt      = 1'b0;
    c_unord   = 1'b0;
    c_invalid = 1'b0;
    c_res     = '0;

    if (s1_a_nan || s1_b_nan) begin
      c_unord = 1'b1;
    end else if (s1_a_zero && s1_b_zero) begin
      c_eq = 1'b1;
    end else if (a_sign != b_sign) begin
      c_lt = a_sign;
      c_gt = b_sign;
    end else if (s1_mag_eq) begin
      c_eq = 1'b1;
    end else begin
      c_gt = s1_mag_gt ^ a_sign;
      c_lt = !(s1_mag_gt ^ a_sign);
    end

    c_invalid = s1_a_snan || s1_b_snan || ((s1_op == OP_CMP_S) && c_unord);

    if (s1_op == OP_MIN || s1_op == OP_MAX) begin
      if (s1_a_snan || s1_b_snan || (s1_a_nan && s1_b_nan)) begin
        c_res = CANON_QNAN;
      end else if (s1_a_nan) begin
        c_res = s1_b;
      end else if (s1_b_nan) begin
        c_res = s1_a;
      end else if (s1_a_zero && s1_b_zero) begin
        // signed zeros: MIN leans negative, MAX leans positive
        c_res = {(s1_op == OP_MIN) ? (a_sign || b_sign) : (a_sign && b_sign), {(W-1){1'b0}}};
      end else if (c_eq) begin
        c_res = s1_a;
      end else if (s1_op == OP_MIN) begin
        c_res = c_lt ? s1_a : s1_b;
      end else begin
        c_res = c_gt ? s1_a : s1_b;
      end
    end
  end

  // stage 2: result register, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      lt       <= 1'b0;
      eq       <= 1'b0;
      gt       <= 1'b0;
      unord    <= 1'b0;
      invalid  <= 1'b0;
      res      <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        lt      <= c_lt;
        eq      <= c_eq;
        gt      <= c_gt;
        unord   <= c_unord;
        invalid <= c_invalid;
        res     <= c_res;
      end
    end
  end

  assign out_valid = s2_valid;

  // sticky exception flag; a delivered invalid result beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_invalid <= 1'b0;
    end else if (s2_valid && out_ready && invalid) begin
      sticky_invalid <= 1'b1;
    end else if (flag_clr) begin
      sticky_invalid <= 1'b0;
    end
  end

endmodule
